// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO with an occupancy count, almost flags,
// error pulses, synchronous flush and optional first-word-fall-through.
module fifo_flex #(
    parameter int Depth             = 8,
    parameter int Width             = 8,
    parameter int Fwft              = 0,
    parameter int AlmostFullThresh  = 6,
    parameter int AlmostEmptyThresh = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_wr,
    input  logic                     i_rd,
    input  logic [Width-1:0]         i_data,
    output logic [Width-1:0]         o_data,
    output logic [$clog2(Depth):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full,
    output logic                     o_almost_empty,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int AW = $clog2(Depth);
    localparam int PW = AW + 1;

    logic [Width-1:0] mem_q [Depth];

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [PW-1:0]    count_q;
    logic [PW-1:0]    count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;

    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [Width-1:0] head;
    logic             empty;
    logic             full;
    logic             rd_ok;
    logic             wr_ok;
    logic             mem_we;

    assign wr_addr = wr_ptr_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];
    assign head    = mem_q[rd_addr];

    // Empty when pointers match; full when addresses match but wrap bits differ.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_addr == rd_addr) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A read frees a slot this cycle, so a write into a full FIFO may pair with it.
    assign rd_ok  = i_rd & ~empty;
    assign wr_ok  = i_wr & (~full | rd_ok);
    assign mem_we = wr_ok & ~i_clr;

    assign o_count        = count_q;
    assign o_empty        = empty;
    assign o_full         = full;
    assign o_almost_full  = (count_q >= PW'(AlmostFullThresh));
    assign o_almost_empty = (count_q <= PW'(AlmostEmptyThresh));
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

    // Next-state for pointers, count and error pulses; flush wins over requests.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (i_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
            overflow_d  = i_wr & ~wr_ok;
            underflow_d = i_rd & ~rd_ok;
        end
    end

    // Control state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents survive reset and flush.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[wr_addr] <= i_data;
        end
    end

    if (Fwft != 0) begin : g_fwft
        assign o_data = head;
    end else begin : g_reg
        logic [Width-1:0] data_q;
        logic [Width-1:0] data_d;

        // Capture the head on an accepted pop; hold otherwise.
        always_comb begin
            data_d = data_q;
            if (rd_ok && !i_clr) begin
                data_d = head;
            end
        end

        // Registered read-data output.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign o_data = data_q;
    end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
Parametrised synchronous single-clock FIFO, the successor to the team's basic buffer FIFO. It adds:
- selectable first-word-fall-through (FWFT) read mode
- an occupancy count
- programmable almost-full and almost-empty flags
- overflow and underflow error pulses
- synchronous flush
- accepted write while full, when a read is accepted in the same cycle

It serves as the general-purpose buffer between streaming blocks in the datapath.

Parameters:
- Depth, 8, number of entries; power of two, at least 2.
- Width, 8, data bits per entry.
- Fwft, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- AlmostFullThresh, 6, o_almost_full asserts when count >= this value; valid range 1..Depth.
- AlmostEmptyThresh, 2, o_almost_empty asserts when count <= this value; valid range 0..Depth-1.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clr  in  1  synchronous flush.
- i_wr  in  1  write request.
- i_rd  in  1  read request (pop).
- i_data  in  Width  write data.
- o_data  out  Width  read data.
- o_count  out  $clog2(Depth)+1  number of stored entries, 0..Depth.
- o_full  out  1  count == Depth.
- o_empty  out  1  count == 0.
- o_almost_full  out  1  count >= AlmostFullThresh.
- o_almost_empty  out  1  count <= AlmostEmptyThresh.
- o_overflow  out  1  one-cycle pulse: a write was rejected.
- o_underflow  out  1  one-cycle pulse: a read was rejected.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - read/write pointers = 0, count = 0.
  - o_empty = 1, o_full = 0, o_almost_empty = 1, o_almost_full = 0.
  - o_overflow = 0, o_underflow = 0.
  - registered o_data = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all entries immediately.
- Pointers: $clog2(Depth)+1 bits, with the extra MSB used as a wrap bit. The address uses the low bits and wraps naturally from Depth-1 to 0.
- The count is a register, updated each cycle by +1, -1 or 0.
- Status flags are decoded from registered count and pointers only. There is no combinational path from i_wr, i_rd or i_clr to any status output.
- Acceptance rules, evaluated on the current-cycle state:
  - rd_ok = i_rd & ~o_empty.
  - wr_ok = i_wr & (~o_full | rd_ok).
  - When full with both requests: both are accepted and the count is unchanged.
  - When empty with both requests: the write is accepted, the read is rejected, and o_underflow pulses. There is no bypass.
- Error pulses, registered and high for exactly the cycle after the offending request:
  - o_overflow = i_wr & ~wr_ok.
  - o_underflow = i_rd & ~rd_ok.
- Fwft = 0 (registered read):
  - On rd_ok, o_data is loaded with the head entry at the next rising edge, giving 1-cycle latency.
  - o_data holds its value when no read is accepted.
- Fwft = 1 (FWFT):
  - o_data always shows the head entry combinationally from the memory at the read pointer.
  - o_data is valid whenever o_empty = 0; i_rd acknowledges and pops it.
  - o_data is don't-care while empty.
  - A word written into an empty FIFO becomes visible the cycle after its write edge.
- i_clr (synchronous):
  - Pointers and count go to 0 and all flags take their reset values.
  - Any i_wr or i_rd in the same cycle is ignored, with no error pulse.
  - In registered mode o_data holds its value.
  - i_clr has priority over all other requests.
- Overflow and underflow never corrupt pointers, count or stored data.
- Almost flags follow the count every cycle; there is no hysteresis.

Test Plan (Depth=8, Width=8, AlmostFullThresh=6, AlmostEmptyThresh=2 unless stated):
1. Reset, then write 0x01..0x08 on 8 consecutive cycles:
   - count steps 1..8.
   - o_almost_empty drops when count = 3.
   - o_almost_full rises when count = 6.
   - o_full rises after the 8th write.
   - A 9th write gives an o_overflow pulse and count stays 8.
2. Fwft=0, from the state left by scenario 1 (8 entries, full), read 8 times:
   - o_data = 0x01..0x08, each appearing one cycle after its i_rd.
   - o_empty = 1 after the last read.
   - A further read gives an o_underflow pulse, and o_data holds 0x08.
3. Fwft=1, write 0xA5 into an empty FIFO:
   - o_empty = 0 and o_data = 0xA5 on the next cycle, before any i_rd.
   - After i_rd, o_empty = 1 and count = 0.
4. While full, assert i_wr=1 and i_rd=1 with i_data=0x55:
   - Both are accepted, count stays 8, no overflow.
   - Draining returns 0x02..0x08, then 0x55.
5. Wrap-around: run 20 cycles of continuous simultaneous write/read at count = 3 with an incrementing data pattern:
   - Output order is preserved across pointer wrap.
   - count stays 3 throughout.
6. With count = 5, assert i_clr together with i_wr:
   - Next cycle count = 0, o_empty = 1, no overflow pulse.
   - Separately, asserting i_rst_n low mid-burst clears all flags asynchronously.
